// File: rtl/spi_defs.sv
// Shared definitions for the SPI initiator: FSM state encodings and
// the electrical levels of the SPI mode used on the link.
package spi_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    TRAIL = 2'd3
  } state_t;

  localparam logic CS_ACTIVE = 1'b0;
  localparam logic SCLK_IDLE = 1'b0;

endpackage

// File: rtl/spi_phase_timer.sv
// Phase timer: counts clk cycles within one SCLK half-period (or the CS hold
// phase) and flags the last cycle of that phase.
module spi_phase_timer #(
  parameter int clkDiv = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic phaseEnd
);

  localparam int cw = $clog2(clkDiv + 1);
  localparam logic [cw-1:0] last_count = cw'(clkDiv - 1);

  logic [cw-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + cw'(1);
    end
  end

  assign phaseEnd = (count == last_count);

endmodule

// File: rtl/spi_master.sv
// SPI initiator: shifts a word out MSB-first on MOSI while capturing MISO,
// with SCLK idling low and an active-low chip select held for a trailing phase.
module spi_master
  import spi_defs::*;
#(
  parameter int width  = 8,
  parameter int clkDiv = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] txData,
  input  logic             miso,
  output logic             sclk,
  output logic             cs,
  output logic             mosi,
  output logic [width-1:0] rxData,
  output logic             busy,
  output logic             done
);

  localparam int bw = $clog2(width);
  localparam logic [bw-1:0] last_bit = bw'(width - 1);

  state_t           state, state_nx;
  logic [width-1:0] shreg, shreg_nx;
  logic [bw-1:0]    bitcnt, bitcnt_nx;
  logic             sclk_nx, cs_nx, mosi_nx, busy_nx, done_nx;
  logic [width-1:0] rx_nx;
  logic             phase_end;
  logic             timer_clear;

  // The phase counter restarts whenever a phase ends and is parked while idle.
  assign timer_clear = (state == IDLE) | phase_end;

  spi_phase_timer #(.clkDiv(clkDiv)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .phaseEnd (phase_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
      sclk   <= SCLK_IDLE;
      cs     <= ~CS_ACTIVE;
      mosi   <= 1'b0;
      rxData <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      bitcnt <= bitcnt_nx;
      sclk   <= sclk_nx;
      cs     <= cs_nx;
      mosi   <= mosi_nx;
      rxData <= rx_nx;
      busy   <= busy_nx;
      done   <= done_nx;
    end
  end

  // One shift register serves both directions: MOSI leaves from the MSB while
  // MISO enters at the LSB on each SCLK rise; MOSI only updates after a fall.
  always_comb begin
    state_nx  = state;
    shreg_nx  = shreg;
    bitcnt_nx = bitcnt;
    sclk_nx   = sclk;
    cs_nx     = cs;
    mosi_nx   = mosi;
    rx_nx     = rxData;
    busy_nx   = busy;
    done_nx   = 1'b0;
    case (state)
      IDLE: begin
        sclk_nx = SCLK_IDLE;
        if (start) begin
          shreg_nx  = txData;
          mosi_nx   = txData[width-1];
          cs_nx     = CS_ACTIVE;
          busy_nx   = 1'b1;
          bitcnt_nx = '0;
          state_nx  = LOW;
        end else begin
          cs_nx   = ~CS_ACTIVE;
          busy_nx = 1'b0;
        end
      end
      LOW: begin
        if (phase_end) begin
          sclk_nx  = ~SCLK_IDLE;
          shreg_nx = {shreg[width-2:0], miso};
          state_nx = HIGH;
        end else begin
          sclk_nx = SCLK_IDLE;
        end
      end
      HIGH: begin
        if (phase_end) begin
          sclk_nx = SCLK_IDLE;
          if (bitcnt < last_bit) begin
            bitcnt_nx = bitcnt + bw'(1);
            mosi_nx   = shreg[width-1];
            state_nx  = LOW;
          end else begin
            state_nx = TRAIL;
          end
        end else begin
          sclk_nx = ~SCLK_IDLE;
        end
      end
      TRAIL: begin
        if (phase_end) begin
          cs_nx    = ~CS_ACTIVE;
          busy_nx  = 1'b0;
          rx_nx    = shreg;
          done_nx  = 1'b1;
          mosi_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          cs_nx = CS_ACTIVE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
